// File: rtl/fx_writeback_queue.sv
// In-order result buffer between the FX unit and the GPR write port; retires XER CA/OV/SO on pop.
// One-cycle push-to-head latency (no bypass); full_o back-pressures dispatch, excess pushes are dropped and flagged.
module fx_writeback_queue #(
  parameter int regWidth   = 5,
  parameter int depth      = 4,
  parameter int countWidth = 3
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                flush_i,
  input  logic                pushValid_i,
  input  logic [0:63]         pushData_i,
  input  logic [regWidth-1:0] pushAddress_i,
  input  logic                pushWriteback_i,
  input  logic                pushXerEnable_i,
  input  logic                pushCarry_i,
  input  logic                pushOverflow_i,
  output logic                full_o,
  output logic [countWidth-1:0] count_o,
  output logic                overflowError_o,
  output logic                wbValid_o,
  input  logic                wbReady_i,
  output logic [0:63]         wbData_o,
  output logic [regWidth-1:0] wbAddress_o,
  output logic                wbWriteEnable_o,
  output logic                xerValid_o,
  output logic                xerCarry_o,
  output logic                xerOverflow_o,
  output logic                xerSummaryOverflow_o
);

  localparam int ptrWidth = $clog2(depth);

  typedef struct packed {
    logic [0:63]         data;
    logic [regWidth-1:0] addr;
    logic                wb;
    logic                xen;
    logic                ca;
    logic                ov;
  } entry_t;

  entry_t                r_mem [depth];
  logic [ptrWidth-1:0]   r_rptr;
  logic [ptrWidth-1:0]   r_wptr;
  logic [countWidth-1:0] r_count;
  logic                  r_overflow_err;
  logic                  r_xer_vld;
  logic                  r_ca;
  logic                  r_ov;
  logic                  r_so;

  entry_t w_head;
  entry_t w_new;
  logic   w_pop;
  logic   w_push;
  logic   w_drop;

  assign w_head = r_mem[r_rptr];
  assign w_new  = '{data: pushData_i, addr: pushAddress_i, wb: pushWriteback_i,
                    xen: pushXerEnable_i, ca: pushCarry_i, ov: pushOverflow_i};

  assign wbValid_o = (r_count != '0);
  assign full_o    = (r_count == countWidth'(depth));

  // A pop frees the slot in the same edge, so a full queue can still take a push.
  assign w_pop  = wbValid_o && wbReady_i;
  assign w_push = pushValid_i && (!full_o || w_pop);
  assign w_drop = pushValid_i && full_o && !w_pop;

  assign count_o              = r_count;
  assign overflowError_o      = r_overflow_err;
  assign wbData_o             = w_head.data;
  assign wbAddress_o          = w_head.addr;
  assign wbWriteEnable_o      = w_head.wb;
  assign xerValid_o           = r_xer_vld;
  assign xerCarry_o           = r_ca;
  assign xerOverflow_o        = r_ov;
  assign xerSummaryOverflow_o = r_so;

  always_ff @(posedge clock_i) begin
    if (w_push && !flush_i) begin
      r_mem[r_wptr] <= w_new;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rptr         <= '0;
      r_wptr         <= '0;
      r_count        <= '0;
      r_overflow_err <= 1'b0;
      r_xer_vld      <= 1'b0;
      r_ca           <= 1'b0;
      r_ov           <= 1'b0;
      r_so           <= 1'b0;
    end else if (flush_i) begin
      r_rptr    <= '0;
      r_wptr    <= '0;
      r_count   <= '0;
      r_xer_vld <= 1'b0;
    end else begin
      r_xer_vld <= w_pop && w_head.xen;
      if (w_push) begin
        r_wptr <= r_wptr + ptrWidth'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + ptrWidth'(1);
        if (w_head.xen) begin
          r_ca <= w_head.ca;
          r_ov <= w_head.ov;
          r_so <= r_so | w_head.ov;
        end
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + countWidth'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - countWidth'(1);
      end
      if (w_drop) begin
        r_overflow_err <= 1'b1;
      end
    end
  end

endmodule
